range_bin_sequencer: RTL

RANGE_BIN_SEQUENCER -- requirements
Module: range_bin_sequencer

---
 rtl/range_bin_sequencer_if.sv | 33 +++
 rtl/range_bin_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/range_bin_sequencer_if.sv
// Bundles the range-bin sequencer's control inputs and status outputs.
// The optional overrun flag exists only when RANGE_BIN_OVERRUN_EN is defined.
interface range_bin_sequencer_if #(
    parameter int BIN_W = 5
);
    logic             cal_done;
    logic             SPEC_Acc_Done;
    logic             wrap_mode;
    logic             cnt_en;
    logic [BIN_W-1:0] bin_counts;
    logic             bin_valid;
    logic             frame_done;
    logic             full;
`ifdef RANGE_BIN_OVERRUN_EN
    logic             overrun;
`endif

    modport master (
        output cal_done, SPEC_Acc_Done, wrap_mode, cnt_en,
        input  bin_counts, bin_valid, frame_done, full
`ifdef RANGE_BIN_OVERRUN_EN
        , input overrun
`endif
    );

    modport slave (
        input  cal_done, SPEC_Acc_Done, wrap_mode, cnt_en,
        output bin_counts, bin_valid, frame_done, full
`ifdef RANGE_BIN_OVERRUN_EN
        , output overrun
`endif
    );
endinterface

// File: rtl/range_bin_sequencer.sv
// Counts delayed cal_done pulses into a bin index, with wrap/saturate at the last bin.
// Define RANGE_BIN_OVERRUN_EN to add a sticky overrun flag for events arriving while FULL.
module range_bin_sequencer #(
    parameter int BIN_W    = 5,
    parameter int NUM_BINS = 32,
    parameter int DLY      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    range_bin_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    logic cal_dly;

    generate
        if (DLY == 0) begin : g_no_dly
            assign cal_dly = bus.cal_done;
        end else begin : g_dly
            logic [DLY-1:0] dly_q;
            logic [DLY-1:0] dly_d;

            always_comb begin
                dly_d    = dly_q << 1;
                dly_d[0] = bus.cal_done;
            end

            // The delay line is deliberately untouched by the frame clear, only by rst.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign cal_dly = dly_q[DLY-1];
        end
    endgenerate

    state_t           state_q, state_d;
    logic [BIN_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             frame_q, frame_d;
    logic             full_q, full_d;
    logic             evt;
    logic             accept;

    assign evt    = cal_dly & bus.cnt_en;
    assign accept = evt & ~bus.SPEC_Acc_Done & (state_q != FULL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        frame_d = 1'b0;
        if (bus.SPEC_Acc_Done) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            if (cnt_q == LAST_BIN) begin
                frame_d = 1'b1;
                if (bus.wrap_mode) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = FULL;
                end
            end else begin
                state_d = COUNT;
                cnt_d   = cnt_q + 1'b1;
            end
        end
        full_d = (state_d == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            full_q  <= full_d;
        end
    end

    assign bus.bin_counts = cnt_q;
    assign bus.bin_valid  = valid_q;
    assign bus.frame_done = frame_q;
    assign bus.full       = full_q;

`ifdef RANGE_BIN_OVERRUN_EN
    logic overrun_q, overrun_d;

    // A coincident frame clear wins over an overrunning event.
    always_comb begin
        overrun_d = overrun_q;
        if (bus.SPEC_Acc_Done) begin
            overrun_d = 1'b0;
        end else if (evt && (state_q == FULL)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun = overrun_q;
`endif

endmodule
